// File: rtl/lcd_8080_responder.sv
// Display-side 8080 bus responder: ILI9341-style command decode into a pixel stream with x/y.
// Write-to-pix_valid/cmd_valid latency is 3 clk from the physical WR rise; no backpressure.
module lcd_8080_responder #(
  parameter int          H_RES     = 240,
  parameter int          V_RES     = 320,
  parameter logic [15:0] DEVICE_ID = 16'h9341
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LCD_CS,
  input  logic        LCD_RS,
  input  logic        LCD_WR,
  input  logic        LCD_RD,
  input  logic [15:0] LCD_DATA,
  output logic [15:0] rd_data,
  output logic        rd_oe,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code
);

  localparam logic [15:0] X_MAX = 16'(H_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(V_RES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_RDID} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cs_s1, r_cs_s2;
  logic        r_rs_s1, r_rs_s2;
  logic        r_wr_s1, r_wr_s2, r_wr_s3;
  logic        r_rd_s1, r_rd_s2, r_rd_s3;
  logic [15:0] r_data_s1, r_data_s2;

  logic [15:0] r_sc, r_ec, r_sp, r_ep;
  logic [15:0] r_x, r_y;
  logic [1:0]  r_param_cnt;
  logic [1:0]  r_rd_idx;

  logic [15:0] r_rd_data;
  logic        r_rd_oe;
  logic        r_pix_valid;
  logic [15:0] r_pix_x, r_pix_y, r_pix_data;
  logic        r_cmd_valid;
  logic [7:0]  r_cmd_code;

  logic        w_wr_evt, w_rd_evt, w_cmd, w_dat;
  logic [7:0]  w_code;
  logic        w_x_last, w_y_last;
  logic [15:0] w_rd_word;

  // Idle bus levels (strobes high) so reset never manufactures an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_s1   <= 1'b1; r_cs_s2 <= 1'b1;
      r_rs_s1   <= 1'b0; r_rs_s2 <= 1'b0;
      r_wr_s1   <= 1'b1; r_wr_s2 <= 1'b1; r_wr_s3 <= 1'b1;
      r_rd_s1   <= 1'b1; r_rd_s2 <= 1'b1; r_rd_s3 <= 1'b1;
      r_data_s1 <= '0;   r_data_s2 <= '0;
    end else begin
      r_cs_s1   <= LCD_CS;   r_cs_s2   <= r_cs_s1;
      r_rs_s1   <= LCD_RS;   r_rs_s2   <= r_rs_s1;
      r_wr_s1   <= LCD_WR;   r_wr_s2   <= r_wr_s1;   r_wr_s3 <= r_wr_s2;
      r_rd_s1   <= LCD_RD;   r_rd_s2   <= r_rd_s1;   r_rd_s3 <= r_rd_s2;
      r_data_s1 <= LCD_DATA; r_data_s2 <= r_data_s1;
    end
  end

  assign w_wr_evt = r_wr_s2 & ~r_wr_s3 & ~r_cs_s2;
  assign w_cmd    = w_wr_evt & ~r_rs_s2;
  assign w_dat    = w_wr_evt &  r_rs_s2;
  assign w_code   = r_data_s2[7:0];
  // A write landing on the same cycle as a read edge wins; the read is dropped.
  assign w_rd_evt = ~r_rd_s2 & r_rd_s3 & ~r_cs_s2 & r_rs_s2 &
                    (r_state == S_RDID) & ~w_wr_evt;

  // Out-of-panel coordinates (window start beyond the panel) also wrap.
  assign w_x_last = (r_x == r_ec) || (r_x >= X_MAX);
  assign w_y_last = (r_y == r_ep) || (r_y >= Y_MAX);

  always_comb begin
    w_rd_word = 16'h0000;
    case (r_rd_idx)
      2'd2:    w_rd_word = {8'h00, DEVICE_ID[15:8]};
      2'd3:    w_rd_word = {8'h00, DEVICE_ID[7:0]};
      default: w_rd_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cmd) begin
      case (w_code)
        8'h2A:   w_state_nxt = S_CASET;
        8'h2B:   w_state_nxt = S_PASET;
        8'h2C:   w_state_nxt = S_RAMWR;
        8'hD3:   w_state_nxt = S_RDID;
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_dat && (r_state == S_CASET || r_state == S_PASET) &&
                 r_param_cnt == 2'd3) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc        <= '0;
      r_ec        <= X_MAX;
      r_sp        <= '0;
      r_ep        <= Y_MAX;
      r_x         <= '0;
      r_y         <= '0;
      r_param_cnt <= '0;
      r_rd_idx    <= '0;
      r_rd_data   <= '0;
      r_rd_oe     <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_data  <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= '0;
    end else begin
      r_pix_valid <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_rd_oe     <= (r_state == S_RDID) & ~r_rd_s2 & ~r_cs_s2;

      if (w_cmd) begin
        r_cmd_valid <= 1'b1;
        r_cmd_code  <= w_code;
        r_param_cnt <= '0;
        r_rd_idx    <= '0;
        if (w_code == 8'h2C) begin
          r_x <= r_sc;
          r_y <= r_sp;
        end else if (w_code == 8'h01) begin
          r_sc <= '0;
          r_ec <= X_MAX;
          r_sp <= '0;
          r_ep <= Y_MAX;
          r_x  <= '0;
          r_y  <= '0;
        end
      end else if (w_dat) begin
        case (r_state)
          S_CASET: begin
            r_param_cnt <= r_param_cnt + 2'd1;
            case (r_param_cnt)
              2'd0: r_sc[15:8] <= w_code;
              2'd1: r_sc[7:0]  <= w_code;
              2'd2: r_ec[15:8] <= w_code;
              2'd3: r_ec[7:0]  <= w_code;
              default: ;
            endcase
          end
          S_PASET: begin
            r_param_cnt <= r_param_cnt + 2'd1;
            case (r_param_cnt)
              2'd0: r_sp[15:8] <= w_code;
              2'd1: r_sp[7:0]  <= w_code;
              2'd2: r_ep[15:8] <= w_code;
              2'd3: r_ep[7:0]  <= w_code;
              default: ;
            endcase
          end
          S_RAMWR: begin
            r_pix_valid <= 1'b1;
            r_pix_x     <= r_x;
            r_pix_y     <= r_y;
            r_pix_data  <= r_data_s2;
            if (w_x_last) begin
              r_x <= r_sc;
              r_y <= w_y_last ? r_sp : r_y + 16'd1;
            end else begin
              r_x <= r_x + 16'd1;
            end
          end
          default: ;
        endcase
      end

      if (w_rd_evt) begin
        r_rd_data <= w_rd_word;
        if (r_rd_idx != 2'd3) r_rd_idx <= r_rd_idx + 2'd1;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_oe     = r_rd_oe;
  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_data  = r_pix_data;
  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;

endmodule
